// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequential dot product of packed element pairs, one element per cycle,
// with valid/ready on both sides. Define MAC_SATURATE_EN to clamp the sum and report overflow.
module mac_dot_seq #(
  parameter int ELEM_WIDTH = 8,
  parameter int NUM_ELEMS  = 3,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                             clk,
  input  logic                             rst_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ELEM_WIDTH*NUM_ELEMS-1:0]  inputattr,
  input  logic [ELEM_WIDTH*NUM_ELEMS-1:0]  inputcoeff,
  input  logic                             signed_mode,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_WIDTH-1:0]             acc,
  output logic                             overflow
);

  localparam int WORD_WIDTH = ELEM_WIDTH * NUM_ELEMS;
  localparam int PROD_WIDTH = 2 * ELEM_WIDTH;
  localparam int WIDE_WIDTH = ACC_WIDTH + 1;
  localparam int IDX_WIDTH  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state;
  logic [WORD_WIDTH-1:0]  attr_q;
  logic [WORD_WIDTH-1:0]  coeff_q;
  logic                   mode_q;
  logic [ACC_WIDTH-1:0]   sum_q;
  logic [ACC_WIDTH-1:0]   sum_next;
  logic [IDX_WIDTH-1:0]   idx;
  logic [ELEM_WIDTH-1:0]  attr_elem;
  logic [ELEM_WIDTH-1:0]  coeff_elem;
  logic [PROD_WIDTH-1:0]  attr_ext;
  logic [PROD_WIDTH-1:0]  coeff_ext;
  logic [PROD_WIDTH-1:0]  prod;

  assign in_ready = (state == IDLE) && rst_in;

  // Operand words shift left each MAC cycle, so the current element is always the top slice.
  // The low 2*ELEM_WIDTH bits of the product are exact for both signed and unsigned operands.
  always_comb begin
    attr_elem  = attr_q[WORD_WIDTH-1 -: ELEM_WIDTH];
    coeff_elem = coeff_q[WORD_WIDTH-1 -: ELEM_WIDTH];
    attr_ext   = {{ELEM_WIDTH{mode_q & attr_elem[ELEM_WIDTH-1]}}, attr_elem};
    coeff_ext  = {{ELEM_WIDTH{mode_q & coeff_elem[ELEM_WIDTH-1]}}, coeff_elem};
    prod       = attr_ext * coeff_ext;
  end

`ifdef MAC_SATURATE_EN
  logic [WIDE_WIDTH-1:0] sum_wide;
  logic [WIDE_WIDTH-1:0] sum_base;
  logic [WIDE_WIDTH-1:0] prod_wide;
  logic [ACC_WIDTH-1:0]  sat_val;
  logic                  ovf_now;
  logic                  ovf_run;
  logic                  ovf_next;
  logic                  ovf_out;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    sum_base  = WIDE_WIDTH'(sum_q);
    prod_wide = WIDE_WIDTH'(prod);
    if (mode_q) begin
      sum_base  = WIDE_WIDTH'($signed(sum_q));
      prod_wide = WIDE_WIDTH'($signed(prod));
    end
    sum_wide = sum_base + prod_wide;
    ovf_now  = mode_q ? (sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1]) : sum_wide[ACC_WIDTH];

    // The extra bit carries the true sign of a signed sum, which picks the clamp direction.
    sat_val = '1;
    if (mode_q) begin
      sat_val = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end

    sum_next = sum_wide[ACC_WIDTH-1:0];
    ovf_next = ovf_run;
    if (ovf_run) begin
      sum_next = sum_q;
    end else if (ovf_now) begin
      sum_next = sat_val;
      ovf_next = 1'b1;
    end
  end

  assign overflow = ovf_out;
`else
  logic [ACC_WIDTH-1:0] prod_acc;

  always_comb begin
    prod_acc = ACC_WIDTH'(prod);
    if (mode_q) begin
      prod_acc = ACC_WIDTH'($signed(prod));
    end
    sum_next = sum_q + prod_acc;
  end

  assign overflow = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      attr_q    <= '0;
      coeff_q   <= '0;
      mode_q    <= 1'b0;
      sum_q     <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
`ifdef MAC_SATURATE_EN
      ovf_run   <= 1'b0;
      ovf_out   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            attr_q  <= inputattr;
            coeff_q <= inputcoeff;
            mode_q  <= signed_mode;
            sum_q   <= '0;
            idx     <= '0;
`ifdef MAC_SATURATE_EN
            ovf_run <= 1'b0;
`endif
            state   <= MAC;
          end
        end

        MAC: begin
          sum_q   <= sum_next;
          attr_q  <= attr_q << ELEM_WIDTH;
          coeff_q <= coeff_q << ELEM_WIDTH;
          idx     <= idx + 1'b1;
`ifdef MAC_SATURATE_EN
          ovf_run <= ovf_next;
`endif
          if (idx == LAST_IDX) begin
            acc       <= sum_next;
`ifdef MAC_SATURATE_EN
            ovf_out   <= ovf_next;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed self-checking bench for mac_dot_seq: a default instance and an ACC_WIDTH=17
// instance driven in lockstep from the same stimulus.
module tb_mac_dot_seq;

  localparam int EW   = 8;
  localparam int NE   = 3;
  localparam int AW   = 20;
  localparam int AW17 = 17;
  localparam int WW   = EW * NE;

`ifdef MAC_SATURATE_EN
  localparam logic [31:0] FULL17_ACC = 32'h1FFFF;
  localparam logic        FULL17_OVF = 1'b1;
`else
  localparam logic [31:0] FULL17_ACC = 32'h0FA03;
  localparam logic        FULL17_OVF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_in;
  logic          in_valid;
  logic          out_ready;
  logic          signed_mode;
  logic [WW-1:0] inputattr;
  logic [WW-1:0] inputcoeff;

  logic            in_ready,   out_valid,   overflow;
  logic [AW-1:0]   acc;
  logic            in_ready17, out_valid17, overflow17;
  logic [AW17-1:0] acc17;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(.ELEM_WIDTH(EW), .NUM_ELEMS(NE), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
    .inputattr(inputattr), .inputcoeff(inputcoeff), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .overflow(overflow)
  );

  mac_dot_seq #(.ELEM_WIDTH(EW), .NUM_ELEMS(NE), .ACC_WIDTH(AW17)) dut17 (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready17),
    .inputattr(inputattr), .inputcoeff(inputcoeff), .signed_mode(signed_mode),
    .out_valid(out_valid17), .out_ready(out_ready), .acc(acc17), .overflow(overflow17)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands for one edge, then scrambles the inputs to show they were captured.
  task automatic send(input logic [WW-1:0] a, input logic [WW-1:0] c, input logic m);
    inputattr   = a;
    inputcoeff  = c;
    signed_mode = m;
    in_valid    = 1'b1;
    check("accept in_ready", in_ready, 1);
    tick();
    in_valid    = 1'b0;
    inputattr   = ~a;
    inputcoeff  = ~c;
    signed_mode = ~m;
    check("busy in_ready", in_ready, 0);
    check("busy in_ready17", in_ready17, 0);
  endtask

  task automatic collect(input string tag, input logic [31:0] e_acc, input logic e_ovf,
                         input logic [31:0] e_acc17, input logic e_ovf17);
    for (int i = 0; i < NE - 1; i++) begin
      tick();
      check({tag, " early out_valid"}, out_valid, 0);
    end
    tick();
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_valid17"}, out_valid17, 1);
    check({tag, " acc"}, acc, e_acc);
    check({tag, " overflow"}, overflow, e_ovf);
    check({tag, " acc17"}, acc17, e_acc17);
    check({tag, " overflow17"}, overflow17, e_ovf17);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, " released out_valid"}, out_valid, 0);
    check({tag, " released in_ready"}, in_ready, 1);
    check({tag, " released in_ready17"}, in_ready17, 1);
  endtask

  initial begin
    rst_in      = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    signed_mode = 1'b0;
    inputattr   = '0;
    inputcoeff  = '0;

    tick();
    tick();
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset acc", acc, 0);
    check("reset overflow", overflow, 0);
    rst_in = 1'b1;
    #1;
    check("post-reset in_ready", in_ready, 1);

    // 1*4 + 2*5 + 3*6 = 32
    send(24'h010203, 24'h040506, 1'b0);
    collect("basic", 32'h20, 1'b0, 32'h20, 1'b0);
    release_result("basic");

    // 3*255*255 = 195075; wraps or saturates in 17 bits
    send(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    collect("max_unsigned", 32'h2FA03, 1'b0, FULL17_ACC, FULL17_OVF);
    release_result("max_unsigned");

    // -1*5 = -5 signed; 255*5 = 1275 unsigned
    send(24'hFF0000, 24'h050000, 1'b1);
    collect("signed_neg", 32'hFFFFB, 1'b0, 32'h1FFFB, 1'b0);
    release_result("signed_neg");
    send(24'hFF0000, 24'h050000, 1'b0);
    collect("unsigned_ff", 32'h004FB, 1'b0, 32'h004FB, 1'b0);
    release_result("unsigned_ff");

    // signed: 127*127 - 128*127 - 1*2 = -129; unsigned: 16129 + 16256 + 510 = 32895
    send(24'h7F80FF, 24'h7F7F02, 1'b1);
    collect("signed_mix", 32'hFFF7F, 1'b0, 32'h1FF7F, 1'b0);
    release_result("signed_mix");
    send(24'h7F80FF, 24'h7F7F02, 1'b0);
    collect("unsigned_mix", 32'h0807F, 1'b0, 32'h0807F, 1'b0);
    release_result("unsigned_mix");

    // Backpressure: 3*(2*3) = 18 held while new operands wait at the input
    out_ready = 1'b0;
    send(24'h020202, 24'h030303, 1'b0);
    collect("stall", 32'h12, 1'b0, 32'h12, 1'b0);
    inputattr   = 24'hFFFFFF;
    inputcoeff  = 24'hFFFFFF;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall hold out_valid", out_valid, 1);
      check("stall hold acc", acc, 32'h12);
      check("stall hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    check("stall release out_valid", out_valid, 0);
    check("stall release in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("stall accept in_ready", in_ready, 0);
    collect("after_stall", 32'h2FA03, 1'b0, FULL17_ACC, FULL17_OVF);
    release_result("after_stall");

    // Reset in the second MAC cycle discards the partial sum and the held result
    send(24'h010203, 24'h040506, 1'b0);
    tick();
    rst_in = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset acc", acc, 0);
    check("midreset acc17", acc17, 0);
    check("midreset overflow17", overflow17, 0);
    check("midreset in_ready", in_ready, 0);
    tick();
    rst_in = 1'b1;
    #1;
    for (int i = 0; i < NE + 1; i++) begin
      tick();
      check("post-midreset no result", out_valid, 0);
    end
    check("post-midreset in_ready", in_ready, 1);
    send(24'h010203, 24'h040506, 1'b0);
    collect("post_reset", 32'h20, 1'b0, 32'h20, 1'b0);
    release_result("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Parametrised sequential dot-product engine: multiplies NUM_ELEMS packed element pairs from an attribute word and a coefficient word and accumulates the products one element per cycle. Operand words enter through a valid/ready handshake and results leave through another valid/ready handshake, so the block can sit between the attribute/coefficient RAM readout and the BDD scoring logic. Element width, element count, accumulator width and signedness are all selectable.

## Interface
- ELEM_WIDTH, 8, bits per packed element
- NUM_ELEMS, 3, elements per operand word (≥1); element 0 is the most-significant slice
- ACC_WIDTH, 20, accumulator/result width (≥ 2*ELEM_WIDTH)
- Derived localparam WORD_WIDTH = ELEM_WIDTH*NUM_ELEMS

- clk  in  1  clock, all state on rising edge
- rst_in  in  1  asynchronous, active-low reset
- in_valid  in  1  operand words valid
- in_ready  out  1  block can accept operands
- inputattr  in  WORD_WIDTH  packed attribute elements
- inputcoeff  in  WORD_WIDTH  packed coefficient elements
- signed_mode  in  1  1 = two's-complement elements, 0 = unsigned; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- acc  out  ACC_WIDTH  dot-product result
- overflow  out  1  result exceeded ACC_WIDTH range (see Configuration)

## Operation
- FSM states: IDLE, MAC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: register inputattr, inputcoeff, signed_mode; clear sum, element index and overflow; go MAC.
- MAC: each cycle add product of element[idx] pair to sum; idx increments 0..NUM_ELEMS-1. On the edge processing idx=NUM_ELEMS-1, load acc with the final sum, set out_valid, go DONE.
- DONE: hold acc, overflow, out_valid. On out_ready: clear out_valid, go IDLE.
- in_ready = (state==IDLE) and rst_in high; in_valid outside IDLE is ignored.
- Arithmetic: elements zero-extended (signed_mode=0) or sign-extended (signed_mode=1); product 2*ELEM_WIDTH bits, extended to ACC_WIDTH+1 before add; overflow detection on the extra bit (unsigned carry-out, or signed range exit).
- Operand registers insulate the computation from input changes after acceptance.

## Timing
- Reset values: in_ready=0 while rst_in low, then 1 (IDLE); out_valid=0, acc=0, overflow=0; state IDLE; internal sum/idx 0.
- Latency: operands accepted at edge N -> out_valid high after edge N+NUM_ELEMS.
- Throughput with out_ready held high: one result per NUM_ELEMS+2 cycles.
- acc and overflow change only on the edge that sets out_valid (or on reset); stable throughout DONE under any backpressure.
- Reset asserted mid-MAC or in DONE: all outputs go to reset values immediately (asynchronously); partial sum discarded; no result emitted.
- NUM_ELEMS=1: MAC lasts exactly one cycle.

## Configuration
- MAC_SATURATE_EN defined: on overflow, the running sum clamps to max (unsigned 2^ACC_WIDTH-1; signed 2^(ACC_WIDTH-1)-1) or signed min -2^(ACC_WIDTH-1), stays clamped in the same direction for the remaining elements, and overflow=1 in the result.
- Not defined: sum wraps modulo 2^ACC_WIDTH; overflow output tied to 0.

## Test plan
- Defaults, unsigned, attr=0x010203, coeff=0x040506, out_ready=1 -> out_valid after 3 edges, acc=0x00020 (32), overflow=0, in_ready back to 1 next cycle.
- Defaults, unsigned, attr=coeff=0xFFFFFF -> acc=0x2FA03 (195075), overflow=0.
- Defaults, signed_mode=1, attr=0xFF0000, coeff=0x050000 -> acc=0xFFFFB (-5); same words unsigned -> acc=0x004FB (1275).
- ACC_WIDTH=17, unsigned, attr=coeff=0xFFFFFF -> with MAC_SATURATE_EN acc=0x1FFFF, overflow=1; without it acc=0x0FA03, overflow=0.
- out_ready held low 5 cycles after result while in_valid=1 with new words -> acc/out_valid stable, in_ready=0, new words not captured; out_ready high -> IDLE, then new words accepted.
- rst_in pulsed low during second MAC cycle -> out_valid=0, acc=0 immediately; after release, attr=0x010203, coeff=0x040506 yields 32 with normal latency.
